// File: rtl/template_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : template_pkg
//  Brief    : Shared types and geometry for the template write/read paths.
//  Revision : 1.0
// ============================================================================
package template_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        AVG     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int TMPL_ROWS    = 16;
    localparam int TMPL_COLS    = 4;
    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 8;
    localparam int ADDR_W       = 7;
    localparam int AVG_LANE_LSB = 24;
    localparam int SUM_W        = 16;
    localparam int LANE_W       = 2;
    localparam int WORD_W       = PIX_PER_WORD * PIX_W;

endpackage
`default_nettype wire

// File: rtl/template_packer.sv
`default_nettype none
// ============================================================================
//  Module   : template_packer
//  Brief    : Packs four pixels per 32-bit word and accumulates the pixel sum.
//  Revision : 1.0
// ============================================================================
module template_packer
    import template_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [PIX_W-1:0]  pixel,
    output logic              word_full,
    output logic [WORD_W-1:0] word,
    output logic [SUM_W-1:0]  sum
);

    logic [LANE_W-1:0] lane;

    // Flags the accept that completes a word, so the FSM can move to WRITE on that same edge.
    assign word_full = accept && (lane == LANE_W'(PIX_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            word <= '0;
            sum  <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
            sum  <= '0;
        end else if (accept) begin
            word[lane*PIX_W +: PIX_W] <= pixel;
            lane                      <= lane + LANE_W'(1);
            sum                       <= sum + SUM_W'(pixel);
        end
    end

endmodule
`default_nettype wire

// File: rtl/template_writer.sv
`default_nettype none
// ============================================================================
//  Module   : template_writer
//  Brief    : Writes a 16x16 pixel template as 32-bit words plus a mean header.
//  Revision : 1.0
// ============================================================================
module template_writer
    import template_pkg::*;
#(
    parameter int ROWS      = TMPL_ROWS,
    parameter int COLS      = TMPL_COLS,
    parameter int AVG_SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              inst,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   row_cnt;
    logic [ADDR_W-1:0]   col_cnt;
    logic                clear;
    logic                accept;
    logic                word_full;
    logic [WORD_W-1:0]   word;
    logic [SUM_W-1:0]    sum;
    logic [PIX_W-1:0]    mean;

    assign clear  = (state == IDLE) && start;
    assign accept = pix_valid && pix_ready;
    assign mean   = PIX_W'(sum >> AVG_SHIFT);

    // Pack register and sum are frozen while a write is pending, so the data bus can be steered from them.
    assign mem_wdata = !mem_we ? '0 :
                       inst    ? {mean, {AVG_LANE_LSB{1'b0}}} : word;

    template_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (accept),
        .pixel     (pix_data),
        .word_full (word_full),
        .word      (word),
        .sum       (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            pix_ready <= 1'b0;
            mem_we    <= 1'b0;
            row       <= '0;
            col       <= '0;
            inst      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (word_full) begin
                        state     <= WRITE;
                        pix_ready <= 1'b0;
                        mem_we    <= 1'b1;
                        row       <= row_cnt;
                        col       <= col_cnt;
                    end
                end
                WRITE: begin
                    if (mem_wready) begin
                        row <= '0;
                        col <= '0;
                        if (col_cnt == LAST_COL && row_cnt == LAST_ROW) begin
                            state <= AVG;
                            inst  <= 1'b1;
                        end else begin
                            state     <= COLLECT;
                            mem_we    <= 1'b0;
                            pix_ready <= 1'b1;
                            if (col_cnt == LAST_COL) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + ADDR_W'(1);
                            end else begin
                                col_cnt <= col_cnt + ADDR_W'(1);
                            end
                        end
                    end
                end
                AVG: begin
                    if (mem_wready) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        inst   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_template_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_template_writer
//  Brief    : Randomized scoreboard bench for template_writer.
//  Revision : 1.0
// ============================================================================
module tb_template_writer;

    typedef struct packed {
        logic        inst;
        logic [6:0]  row;
        logic [6:0]  col;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_wready;
    logic [6:0]  row;
    logic [6:0]  col;
    logic        inst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    template_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_wready (mem_wready),
        .row        (row),
        .col        (col),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    wr_t  sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] pm [256];
    int   idx         = 0;
    int   accept_cnt  = 0;
    int   done_cnt    = 0;
    int   stall_left  = 0;
    int   stall_cycles = 0;
    int   vmode       = 0;
    int   rmode       = 0;
    bit   feeding     = 0;
    bit   acc_pending = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: word w holds pixels 4w..4w+3 little-endian at (w/4, w%4); header holds floor(sum/256).
    task automatic build_expected();
        int total;
        wr_t e;
        total = 0;
        for (int w = 0; w < 64; w++) begin
            e.inst = 1'b0;
            e.row  = 7'(w / 4);
            e.col  = 7'(w % 4);
            e.data = {pm[4*w+3], pm[4*w+2], pm[4*w+1], pm[4*w]};
            for (int k = 0; k < 4; k++) total += int'(pm[4*w+k]);
            sb.push_back(e);
        end
        e.inst = 1'b1;
        e.row  = 7'd0;
        e.col  = 7'd0;
        e.data = 32'(total / 256) << 24;
        sb.push_back(e);
    endtask

    // Driver: inputs change 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            acc_pending = 0;
        end else begin
            if (acc_pending) idx++;
            case (rmode)
                0: mem_wready = 1'b1;
                1: mem_wready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (mem_we && !inst && row == 7'd3 && col == 7'd2 && stall_left > 0) begin
                        mem_wready = 1'b0;
                        stall_left--;
                    end else begin
                        mem_wready = 1'b1;
                    end
                end
            endcase
            if (feeding && idx < 256) begin
                case (vmode)
                    0: pix_valid = 1'b1;
                    1: pix_valid = ~pix_valid;
                    default: pix_valid = 1'($urandom_range(0, 1));
                endcase
                pix_data = pix_valid ? pm[idx] : 8'($urandom);
            end else begin
                pix_valid = 1'b0;
            end
            acc_pending = pix_valid && pix_ready;
            if (acc_pending) accept_cnt++;
        end
    end

    // Monitor: samples on the falling edge and checks each accepted write against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_we && mem_wready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got inst=%b row=%0d col=%0d data=%h expected none",
                             inst, row, col, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("write", 64'({inst, row, col, mem_wdata}), 64'(e));
                end
            end
            if (rmode == 2 && mem_we && !mem_wready && sb.size() > 0) begin
                stall_cycles++;
                check("stall_hold", 64'({pix_ready, mem_we, inst, row, col, mem_wdata}),
                      64'({1'b0, 1'b1, 1'b0, 7'd3, 7'd2, sb[0].data}));
            end
        end
    end

    task automatic run_tmpl(input int pat, input int vm, input int rm,
                            input bit check_cyc, input int special);
        int  cyc;
        bit  got;
        bit  pulsed;
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0: pm[i] = 8'h10;
                1: pm[i] = 8'(i);
                2: pm[i] = 8'($urandom);
                default: pm[i] = 8'hFF;
            endcase
        end
        sb.delete();
        build_expected();
        idx          = 0;
        accept_cnt   = 0;
        done_cnt     = 0;
        stall_left   = 5;
        stall_cycles = 0;
        vmode        = vm;
        rmode        = rm;
        pix_valid    = 1'b0;
        @(posedge clk);
        #2;
        start   = 1'b1;
        feeding = 1;
        cyc     = 0;
        got     = 0;
        pulsed  = 0;
        while (cyc < 4000 && !got) begin
            @(posedge clk);
            #2;
            cyc++;
            start = 1'b0;
            if (special == 1 && !pulsed && mem_we && !inst && row == 7'd7) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (special == 2 && mem_we && !inst && row == 7'd9 && col == 7'd1) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid", 64'({pix_ready, mem_wdata, mem_we, row, col, inst, busy, done}), 64'd0);
                feeding   = 0;
                pix_valid = 1'b0;
                sb.delete();
                @(posedge clk);
                #2;
                rst_n = 1'b1;
                return;
            end
            if (done) got = 1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end else if (check_cyc) begin
            check("done_cycle", 64'(cyc), 64'd322);
        end
        repeat (3) @(posedge clk);
        #2;
        feeding = 0;
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("accepts", 64'(accept_cnt), 64'd256);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        if (rm == 2) check("stall_cycles", 64'(stall_cycles), 64'd5);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        pix_data   = 8'd0;
        pix_valid  = 1'b0;
        mem_wready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", 64'({pix_ready, mem_wdata, mem_we, row, col, inst, busy, done}), 64'd0);
        rst_n = 1'b1;

        run_tmpl(0, 0, 0, 1, 0);   // constant 0x10
        run_tmpl(1, 0, 0, 1, 0);   // index ramp
        run_tmpl(1, 0, 2, 0, 0);   // stall on (3,2)
        run_tmpl(1, 1, 0, 0, 0);   // toggling valid
        run_tmpl(2, 2, 1, 0, 0);   // random pixels, valid and wready
        run_tmpl(2, 0, 0, 1, 1);   // start pulsed while busy
        run_tmpl(2, 0, 0, 0, 2);   // reset during (9,1)
        run_tmpl(3, 0, 0, 1, 0);   // all 0xFF after reset

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/template_writer.md
Name: template_writer

Overview:
- Packs a 16x16 8-bit template pixel stream into 32-bit memory words and writes them at (row, col) word addresses.
- Accumulates the pixel sum and, after the last data word, writes the floor-mean into the instruction/header word.
- Producer side of the template memory image that the template read path consumes: data words at row 0..15, col 0..3; mean in bits [31:24] of the inst-selected word.

Parameters:
- ROWS, 16, template rows; also words per column.
- COLS, 4, 32-bit words per row (4 pixels per word).
- AVG_SHIFT, 8, log2(ROWS*COLS*4); pixel count must be a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one template write; sampled only in IDLE
- pix_data  in  8  unsigned pixel, raster order
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  writer accepts pixel this cycle
- mem_wdata  out  32  write data
- mem_we  out  1  write request
- mem_wready  in  1  memory accepts write this cycle
- row  out  7  word row address
- col  out  7  word column address
- inst  out  1  select instruction/header register instead of data array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the header write is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; row/col counters, lane index, sum and pack register all 0.
- Pixel handshake: a pixel is accepted when pix_valid && pix_ready. pix_ready is high only in COLLECT.
- States:
  - IDLE: start -> COLLECT; clear sum, lane, row, col.
  - COLLECT: pixel at lane k goes to pack[8k+7:8k], with the first pixel in [7:0]. sum += pix_data. After the lane-3 accept -> WRITE.
  - WRITE: mem_we=1, mem_wdata=pack, row/col = counters, inst=0. Outputs are held stable until mem_wready.
    - On accept with col==COLS-1 and row==ROWS-1 -> AVG.
    - Otherwise col wraps to 0 and row increments when col==COLS-1, else col increments; -> COLLECT.
  - AVG: mem_we=1, inst=1, row=col=0, mem_wdata={sum[AVG_SHIFT+7:AVG_SHIFT], 24'b0}. Held until mem_wready, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Sum width: 16 bits (max 255*256=65280, no overflow). Mean = sum>>AVG_SHIFT (truncating).
- Throughput: at most one pixel per cycle. Each data word costs 4 accept cycles plus at least 1 WRITE cycle. With continuous valid and a ready memory, a full template takes 64*5+2 = 322 cycles from start to done.
- mem_we is asserted only in WRITE and AVG. row/col are 0 outside WRITE.
- start while busy: ignored; start in the DONE cycle: ignored.
- pix_valid outside COLLECT: ignored; no pixel is consumed.
- mem_wready outside WRITE/AVG: ignored.
- Reset mid-operation: immediate return to IDLE with reset values. Partially written memory is not repaired; the next start rewrites everything.

Decomposition:
- Package template_pkg holds:
  - state enum {IDLE, COLLECT, WRITE, AVG, DONE};
  - constants TMPL_ROWS=16, TMPL_COLS=4, PIX_PER_WORD=4;
  - PIX_W=8, ADDR_W=7, AVG_LANE_LSB=24.
- These are shared with the template read path.
- One sub-module, template_packer: lane counter, 32-bit pack register and 16-bit sum accumulator. It has clear, accept and pixel inputs and word_full, word and sum outputs.
- The FSM and address counters stay in template_writer.

Test Plan:
- All pixels 8'h10, pix_valid constant, mem_wready constant 1:
  - 64 writes, each mem_wdata=32'h10101010;
  - addresses (0,0),(0,1)..(15,3);
  - then inst=1 write 32'h10000000;
  - done at cycle 322 after start.
- Pixel value = index mod 256 (0..255): first word 32'h03020100, word (15,3)=32'hFFFEFDFC. Sum=32640, mean=127, so header=32'h7F000000.
- mem_wready held low 5 cycles on write (3,2): mem_we, mem_wdata, row=3, col=2 stable all 5 cycles. pix_ready=0 throughout and no pixel is lost.
- pix_valid toggled 1/0 every cycle: word contents identical to the continuous case; pixel-accept count is exactly 256.
- start pulsed again during row 7: ignored, sequence completes normally with exactly one done pulse.
- rst_n asserted during WRITE of (9,1): all outputs 0 immediately. New start with all pixels 8'hFF produces 64 words of 32'hFFFFFFFF and header 32'hFF000000.
